// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_MULU = 2'b01;
  localparam logic [1:0] OP_DIV  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } state_t;

endpackage

// File: rtl/muldiv_abs.sv
// Combinational conditional two's-complement negate (magnitude or sign fix-up).
module muldiv_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    if (neg) result = ~value + WIDTH'(1);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Shared shift-add multiplier / restoring divider for mult, multu, div, divu.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  state_t state, state_next;

  logic               is_div_q, sign_a, sign_b, dz_pend;
  logic [WIDTH-1:0]   a_q, b_q, m_q;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;

  logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
  logic [2*WIDTH-1:0] prod_fix, step;
  logic [WIDTH:0]     add_sum, rem_shift, rem_diff;
  logic               b_zero_div, accept, finish;

  muldiv_abs #(.WIDTH(WIDTH))   u_abs_a    (.value(a_q), .neg(sign_a), .result(mag_a));
  muldiv_abs #(.WIDTH(WIDTH))   u_abs_b    (.value(b_q), .neg(sign_b), .result(mag_b));
  muldiv_abs #(.WIDTH(2*WIDTH)) u_fix_prod (.value(acc), .neg(sign_a ^ sign_b), .result(prod_fix));
  muldiv_abs #(.WIDTH(WIDTH))   u_fix_q    (.value(acc[WIDTH-1:0]),
                                            .neg((sign_a ^ sign_b) & ~dz_pend), .result(q_fix));
  muldiv_abs #(.WIDTH(WIDTH))   u_fix_r    (.value(acc[2*WIDTH-1:WIDTH]),
                                            .neg(sign_a & ~dz_pend), .result(r_fix));

  always_comb begin
    b_zero_div = is_div_q && (b_q == '0);
    busy       = (state != S_IDLE);
    accept     = (state == S_IDLE) && start && !flush;
    finish     = (state == S_FIX) && !flush;
  end

  // acc is {product_hi, multiplier} for multiply and {remainder, quotient} for divide;
  // remainder < divisor keeps the shifted value below 2*divisor, so bit WIDTH is the borrow.
  always_comb begin
    add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m_q} : '0);
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, m_q};
    if (is_div_q)
      step = {rem_diff[WIDTH] ? rem_shift[WIDTH-1:0] : rem_diff[WIDTH-1:0],
              acc[WIDTH-2:0], ~rem_diff[WIDTH]};
    else
      step = {add_sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_PREP;
      S_PREP:  state_next = b_zero_div ? S_FIX : S_CALC;
      S_CALC:  if (cnt == CNT_W'(1)) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      dz_pend  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          is_div_q <= (op == OP_DIV) || (op == OP_DIVU);
          sign_a   <= ((op == OP_MUL) || (op == OP_DIV)) && a[WIDTH-1];
          sign_b   <= ((op == OP_MUL) || (op == OP_DIV)) && b[WIDTH-1];
          a_q      <= a;
          b_q      <= b;
          div_zero <= 1'b0;
        end
        S_PREP: begin
          cnt     <= CNT_W'(WIDTH);
          dz_pend <= b_zero_div;
          m_q     <= is_div_q ? mag_b : mag_a;
          acc     <= b_zero_div ? {a_q, {WIDTH{1'b1}}}
                                : {{WIDTH{1'b0}}, (is_div_q ? mag_a : mag_b)};
        end
        S_CALC: begin
          cnt <= cnt - CNT_W'(1);
          acc <= step;
        end
        S_FIX: if (finish) begin
          hi       <= is_div_q ? r_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo       <= is_div_q ? q_fix : prod_fix[WIDTH-1:0];
          done     <= 1'b1;
          div_zero <= dz_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: WIDTH=32 directed cases plus WIDTH=8 random traffic vs a reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        start_w[2];
  logic [1:0]  op_w[2];
  logic [31:0] a_w[2];
  logic [31:0] b_w[2];
  logic        flush_w[2];
  logic        busy_w[2];
  logic        done_w[2];
  logic        dz_w[2];
  logic [31:0] hi_w[2];
  logic [31:0] lo_w[2];

  logic [31:0] hi0, lo0;
  logic [7:0]  hi1, lo1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start_w[0]), .op(op_w[0]), .a(a_w[0]), .b(b_w[0]),
    .flush(flush_w[0]), .hi(hi0), .lo(lo0), .busy(busy_w[0]), .done(done_w[0]),
    .div_zero(dz_w[0])
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start_w[1]), .op(op_w[1]), .a(a_w[1][7:0]), .b(b_w[1][7:0]),
    .flush(flush_w[1]), .hi(hi1), .lo(lo1), .busy(busy_w[1]), .done(done_w[1]),
    .div_zero(dz_w[1])
  );

  always_comb begin
    hi_w[0] = hi0;
    lo_w[0] = lo0;
    hi_w[1] = {24'h0, hi1};
    lo_w[1] = {24'h0, lo1};
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int uw(input int k);
    return (k == 0) ? 32 : 8;
  endfunction

  // Reference result straight from the arithmetic definition: {div_zero, hi, lo}.
  function automatic logic [64:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                         input logic [31:0] y, input int w);
    longint mask, ua, ub, sa, sb, p, rh, rl;
    logic   dz;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(y) & mask;
    sa = (ua << (64 - w)) >>> (64 - w);
    sb = (ub << (64 - w)) >>> (64 - w);
    dz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; rh = p >> w; rl = p; end
      2'b01: begin p = ua * ub; rh = p >> w; rl = p; end
      default: begin
        if (ub == 0) begin
          dz = 1'b1; rl = mask; rh = ua;
        end else if (o == 2'b10) begin
          rl = sa / sb; rh = sa % sb;
        end else begin
          rl = ua / ub; rh = ua % ub;
        end
      end
    endcase
    rh = rh & mask;
    rl = rl & mask;
    return {dz, 32'(rh), 32'(rl)};
  endfunction

  // Transaction-level model: accepted request completes after a fixed latency unless flushed.
  logic        m_busy[2], m_done[2], m_dz[2], p_dz[2];
  logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  int          m_rem[2], m_ndone[2];
  logic [64:0] m_res;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_done[k] = 0; m_dz[k] = 0; p_dz[k] = 0;
      m_hi[k] = 0; m_lo[k] = 0; p_hi[k] = 0; p_lo[k] = 0;
      m_rem[k] = 0; m_ndone[k] = 0;
      start_w[k] = 0; op_w[k] = 0; a_w[k] = 0; b_w[k] = 0; flush_w[k] = 0;
    end
  end

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_busy[k] = 0; m_done[k] = 0; m_dz[k] = 0; m_hi[k] = 0; m_lo[k] = 0; m_rem[k] = 0;
      end else begin
        m_done[k] = 0;
        if (m_busy[k]) begin
          if (flush_w[k]) m_busy[k] = 0;
          else begin
            m_rem[k]--;
            if (m_rem[k] == 0) begin
              m_busy[k] = 0; m_done[k] = 1;
              m_hi[k] = p_hi[k]; m_lo[k] = p_lo[k]; m_dz[k] = p_dz[k];
              m_ndone[k]++;
            end
          end
        end else if (start_w[k] && !flush_w[k]) begin
          m_res = ref_op(op_w[k], a_w[k], b_w[k], uw(k));
          p_dz[k] = m_res[64];
          p_hi[k] = m_res[63:32];
          p_lo[k] = m_res[31:0];
          m_rem[k] = m_res[64] ? 2 : uw(k) + 2;
          m_busy[k] = 1;
          m_dz[k] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d busy", k), 32'(busy_w[k]), 32'(m_busy[k]));
        check($sformatf("u%0d done", k), 32'(done_w[k]), 32'(m_done[k]));
        check($sformatf("u%0d div_zero", k), 32'(dz_w[k]), 32'(m_dz[k]));
        check($sformatf("u%0d hi", k), hi_w[k], m_hi[k]);
        check($sformatf("u%0d lo", k), lo_w[k], m_lo[k]);
        check($sformatf("u%0d busy&done", k), 32'(busy_w[k] & done_w[k]), 32'h0);
      end
    end
  end

  // Drives a request on the 32-bit unit for one cycle starting at the current negedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start_w[0] = 1'b1; op_w[0] = o; a_w[0] = x; b_w[0] = y;
    @(negedge clk);
    start_w[0] = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done_w[0] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz, input int elat);
    int lat;
    @(negedge clk);
    issue(o, x, y);
    wait_done(lat);
    check({nm, " latency"}, 32'(lat), 32'(elat));
    check({nm, " hi"}, hi_w[0], ehi);
    check({nm, " lo"}, lo_w[0], elo);
    check({nm, " div_zero"}, 32'(dz_w[0]), 32'(edz));
  endtask

  task automatic quiet(input string nm, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done_w[0]) seen++;
    end
    check({nm, " no done"}, 32'(seen), 32'h0);
  endtask

  function automatic logic [31:0] pick8();
    case ($urandom_range(0, 7))
      0: return 32'h00;
      1: return 32'h80;
      2: return 32'hFF;
      3: return 32'h7F;
      4: return 32'h01;
      default: return 32'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset u%0d hi", k), hi_w[k], 32'h0);
      check($sformatf("reset u%0d lo", k), lo_w[k], 32'h0);
      check($sformatf("reset u%0d busy", k), 32'(busy_w[k]), 32'h0);
      check($sformatf("reset u%0d done", k), 32'(done_w[k]), 32'h0);
      check($sformatf("reset u%0d div_zero", k), 32'(dz_w[k]), 32'h0);
    end

    run("mul -3*7",   2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run("mulu",       2'b01, 32'hFFFFFFFD, 32'd7, 32'h00000006, 32'hFFFFFFEB, 1'b0, 34);
    run("div -7/2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    run("divu 7/2",   2'b11, 32'd7,        32'd2, 32'd1,        32'd3,        1'b0, 34);
    run("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 34);
    run("divu 5/0",   2'b11, 32'd5,        32'd0, 32'd5,        32'hFFFFFFFF, 1'b1, 2);

    @(negedge clk);
    issue(2'b01, 32'd2, 32'd3);
    check("div_zero cleared on start", 32'(dz_w[0]), 32'h0);
    wait_done(lat);
    check("mulu 2*3 lo", lo_w[0], 32'd6);

    // A second request while busy must not disturb the first.
    @(negedge clk);
    issue(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    start_w[0] = 1'b1; op_w[0] = 2'b11; a_w[0] = 32'd100; b_w[0] = 32'd7;
    @(negedge clk);
    start_w[0] = 1'b0;
    wait_done(lat);
    check("busy start latency", 32'(lat), 32'd28);
    check("busy start hi", hi_w[0], 32'h0);
    check("busy start lo", lo_w[0], 32'd15);
    quiet("busy start", 40);

    // Back-to-back: next start issued in the done cycle.
    @(negedge clk);
    issue(2'b01, 32'd4, 32'd5);
    wait_done(lat);
    check("b2b first lo", lo_w[0], 32'd20);
    issue(2'b01, 32'd6, 32'd7);
    wait_done(lat);
    check("b2b second latency", 32'(lat), 32'd34);
    check("b2b second hi", hi_w[0], 32'h0);
    check("b2b second lo", lo_w[0], 32'd42);

    @(negedge clk);
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(negedge clk);
    flush_w[0] = 1'b1;
    @(negedge clk);
    flush_w[0] = 1'b0;
    check("flush busy drop", 32'(busy_w[0]), 32'h0);
    quiet("flush", 40);
    check("flush hi kept", hi_w[0], 32'h0);
    check("flush lo kept", lo_w[0], 32'd42);

    @(negedge clk);
    start_w[0] = 1'b1; flush_w[0] = 1'b1; op_w[0] = 2'b00; a_w[0] = 32'd9; b_w[0] = 32'd9;
    @(negedge clk);
    start_w[0] = 1'b0; flush_w[0] = 1'b0;
    check("flush+start busy", 32'(busy_w[0]), 32'h0);
    quiet("flush+start", 40);
    check("flush+start lo kept", lo_w[0], 32'd42);

    // Random traffic on the 8-bit unit, including starts while busy and stray flushes.
    for (int cyc = 0; cyc < 30000 && m_ndone[1] < 500; cyc++) begin
      @(negedge clk);
      start_w[1] = ($urandom_range(0, 2) == 0);
      flush_w[1] = ($urandom_range(0, 49) == 0);
      op_w[1] = 2'($urandom_range(0, 3));
      a_w[1] = pick8();
      b_w[1] = pick8();
    end
    @(negedge clk);
    start_w[1] = 1'b0; flush_w[1] = 1'b0;
    repeat (20) @(negedge clk);
    check("random completions >= 500", 32'(m_ndone[1] >= 500), 32'h1);

    @(negedge clk);
    issue(2'b00, 32'h00012345, 32'h00000777);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async rst u%0d hi", k), hi_w[k], 32'h0);
      check($sformatf("async rst u%0d lo", k), lo_w[k], 32'h0);
      check($sformatf("async rst u%0d busy", k), 32'(busy_w[k]), 32'h0);
      check($sformatf("async rst u%0d done", k), 32'(done_w[k]), 32'h0);
    end
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
